// File: rtl/mem_access_unit_pkg.sv
// Shared types for mem_access_unit: FSM states,
// byte-enable constants, MemtoReg encodings.
package mem_access_unit_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  function automatic logic [3:0] byte_be(
    input logic [1:0] lane
  );
    return BE_BYTE << lane;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and memory (slave).
// req/we/addr/wdata/be issue an access; ack/rdata complete it.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: picks the byte lane of rdata and sign-extends it.
// Ports: rdata/lane/word in, data out (word=1 passes rdata through).
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        word,
  output logic [31:0] data
);

  logic [7:0] b;

  always_comb begin
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    data = word ? rdata : {{24{b[7]}}, b};
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores on the dmem bus, stalls upstream,
// and registers MEM/WB results. Ports: clk, reset (async, high),
// EX/MEM inputs, dmem master, stall, *_out results.
// MEM_MISALIGN_TRAP_EN: misaligned word access traps instead of
// silently clearing the low address bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] ALUresult,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  input  logic [1:0]  MemtoReg,
  input  logic        RegWrite,
  input  logic        WordOrByte,
  input  logic        MemRead,
  input  logic        MemWrite,
  mem_access_unit_if.master dmem,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic [1:0]  MemtoReg_out,
  output logic        RegWrite_out,
  output logic        valid_out,
  output logic        err_out
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW:0] WAIT_LIM = (CW+1)'(MAX_WAIT);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] ld_q, ld_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [1:0]  mtr_q, mtr_d;
  logic        rw_q, rw_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic        mem_op, busy, ack;
  logic        timeout, done, misalign, cap;
  logic [31:0] aligned;

  assign mem_op  = MemRead | MemWrite;
  assign busy    = (state_q == S_BUSY);
  assign ack     = busy & dmem.dmem_ack;
  // cnt_inc counts the current BUSY cycle too
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign timeout = busy & ~dmem.dmem_ack
                 & (cnt_inc == WAIT_LIM);
  assign done    = ack | timeout;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ~busy & mem_op & WordOrByte
                  & (ALUresult[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign stall = mem_op & ~done & ~misalign;

  load_align u_align (
    .rdata (dmem.dmem_rdata),
    .lane  (addr_q[1:0]),
    .word  (be_q == BE_WORD),
    .data  (aligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    pc_out_d  = pc_out_q;
    alu_out_d = alu_out_q;
    ld_d      = ld_q;
    rd_out_d  = rd_out_q;
    mtr_d     = mtr_q;
    rw_d      = 1'b0;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    cap       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (misalign) begin
          cap   = 1'b1;
          vld_d = 1'b1;
          err_d = 1'b1;
        end else if (mem_op) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = MemWrite;
          if (WordOrByte) begin
            addr_d  = {ALUresult[31:2], 2'b00};
            be_d    = BE_WORD;
            wdata_d = rs2;
          end else begin
            addr_d  = ALUresult;
            be_d    = byte_be(ALUresult[1:0]);
            wdata_d = {4{rs2[7:0]}};
          end
        end else begin
          cap   = 1'b1;
          vld_d = 1'b1;
          rw_d  = RegWrite;
        end
      end
      S_BUSY: begin
        if (done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          cap     = 1'b1;
          vld_d   = 1'b1;
          rw_d    = ack & RegWrite;
          err_d   = timeout;
          if (ack & ~we_q) ld_d = aligned;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
    endcase
    if (cap) begin
      pc_out_d  = pc;
      alu_out_d = ALUresult;
      rd_out_d  = rd;
      mtr_d     = MemtoReg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      pc_out_q  <= '0;
      alu_out_q <= '0;
      ld_q      <= '0;
      rd_out_q  <= '0;
      mtr_q     <= '0;
      rw_q      <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      pc_out_q  <= pc_out_d;
      alu_out_q <= alu_out_d;
      ld_q      <= ld_d;
      rd_out_q  <= rd_out_d;
      mtr_q     <= mtr_d;
      rw_q      <= rw_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign pc_out        = pc_out_q;
  assign ALUresult_out = alu_out_q;
  assign load_data     = ld_q;
  assign rd_out        = rd_out_q;
  assign MemtoReg_out  = mtr_q;
  assign RegWrite_out  = rw_q;
  assign valid_out     = vld_q;
  assign err_out       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a memory responder
// and a completion scoreboard.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, ALUresult, rs2;
  logic [4:0]  rd;
  logic [1:0]  MemtoReg;
  logic        RegWrite, WordOrByte, MemRead, MemWrite;
  logic        stall;
  logic [31:0] pc_out, ALUresult_out, load_data;
  logic [4:0]  rd_out;
  logic [1:0]  MemtoReg_out;
  logic        RegWrite_out, valid_out, err_out;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .ALUresult     (ALUresult),
    .rs2           (rs2),
    .rd            (rd),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .WordOrByte    (WordOrByte),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .dmem          (bus),
    .stall         (stall),
    .pc_out        (pc_out),
    .ALUresult_out (ALUresult_out),
    .load_data     (load_data),
    .rd_out        (rd_out),
    .MemtoReg_out  (MemtoReg_out),
    .RegWrite_out  (RegWrite_out),
    .valid_out     (valid_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic [1:0]  mtr;
    logic        rw;
    logic        err;
    logic        chk_ld;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_fail = 0;

  int          ack_after = -1;
  logic [31:0] rdata_val = '0;
  bit          force_ack = 1'b0;
  int          busy_n = 0;

  int          n_stall, n_req;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic        c_we, v_first;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, a,
                      input logic [4:0] r,
                      input logic [1:0] m,
                      input logic w, er, cl,
                      input logic [31:0] l);
    exp_t x;
    x.pc = p; x.alu = a; x.rd = r; x.mtr = m;
    x.rw = w; x.err = er; x.chk_ld = cl; x.ld = l;
    sb.push_back(x);
  endtask

  // Memory model: acks after ack_after BUSY cycles (-1: never).
  always @(posedge clk) begin
    #1;
    if (reset || !bus.dmem_req) begin
      busy_n = 0;
      bus.dmem_ack = force_ack;
      bus.dmem_rdata = '0;
    end else begin
      bus.dmem_ack = (ack_after >= 0) && (busy_n == ack_after);
      bus.dmem_rdata = bus.dmem_ack ? rdata_val : 32'h0;
      busy_n++;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_extra: valid_out=1 want none pending");
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pc_out", pc_out, e.pc);
          check("alu_out", ALUresult_out, e.alu);
          check("rd_out", 32'(rd_out), 32'(e.rd));
          check("mtr_out", 32'(MemtoReg_out), 32'(e.mtr));
          check("rw_out", 32'(RegWrite_out), 32'(e.rw));
          check("err_out", 32'(err_out), 32'(e.err));
          if (e.chk_ld) check("load_data", load_data, e.ld);
        end
      end else begin
        check("bubble_rw", 32'(RegWrite_out), 32'd0);
        check("bubble_err", 32'(err_out), 32'd0);
      end
    end
  end

  task automatic run_op(input logic [31:0] a_pc, a_alu, a_rs2,
                        input logic [4:0] a_rd,
                        input logic [1:0] a_mtr,
                        input logic a_rw, a_wob, a_mr, a_mw);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc = a_pc; ALUresult = a_alu; rs2 = a_rs2;
    rd = a_rd; MemtoReg = a_mtr; RegWrite = a_rw;
    WordOrByte = a_wob; MemRead = a_mr; MemWrite = a_mw;
    n_stall = 0; n_req = 0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    @(negedge clk);
    v_first = valid_out;
    for (int i = 0; i < 64; i++) begin
      if (bus.dmem_req) begin
        if (n_req == 0) begin
          c_addr = bus.dmem_addr;
          c_wdata = bus.dmem_wdata;
          c_be = bus.dmem_be;
          c_we = bus.dmem_we;
        end
        n_req++;
      end
      if (!stall) begin
        ok = 1'b1;
        break;
      end
      n_stall++;
      @(negedge clk);
    end
    check("op_done", 32'(ok), 32'd1);
  endtask

  initial begin
    pc = '0; ALUresult = '0; rs2 = '0; rd = '0;
    MemtoReg = '0; RegWrite = 1'b0; WordOrByte = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_ld", load_data, 32'd0);

    // plain ALU op passes through
    push(32'h1000, 32'h55, 5'd3, MTR_ALU, 1'b1, 1'b0, 1'b0, '0);
    run_op(32'h1000, 32'h55, 32'h0, 5'd3, MTR_ALU,
           1'b1, 1'b1, 1'b0, 1'b0);
    check("nop_stall", 32'(n_stall), 32'd0);
    check("nop_req", 32'(n_req), 32'd0);
    check("first_valid", 32'(v_first), 32'd0);

    // word load, ack after 3 cycles
    ack_after = 3; rdata_val = 32'hDEADBEEF;
    push(32'h1004, 32'h100, 5'd5, MTR_MEM, 1'b1, 1'b0, 1'b1,
         32'hDEADBEEF);
    run_op(32'h1004, 32'h100, 32'h0, 5'd5, MTR_MEM,
           1'b1, 1'b1, 1'b1, 1'b0);
    check("lw_stall", 32'(n_stall), 32'd4);
    check("lw_req", 32'(n_req), 32'd4);
    check("lw_be", 32'(c_be), 32'hF);
    check("lw_addr", c_addr, 32'h100);
    check("lw_we", 32'(c_we), 32'd0);
    check("lw_vprev", 32'(v_first), 32'd1);

    // byte store, ack after 1 cycle
    ack_after = 1;
    push(32'h1008, 32'h203, 5'd0, MTR_ALU, 1'b0, 1'b0, 1'b0, '0);
    run_op(32'h1008, 32'h203, 32'hA5, 5'd0, MTR_ALU,
           1'b0, 1'b0, 1'b0, 1'b1);
    check("sb_stall", 32'(n_stall), 32'd2);
    check("sb_be", 32'(c_be), 32'h8);
    check("sb_wdata", c_wdata, 32'hA5A5A5A5);
    check("sb_we", 32'(c_we), 32'd1);
    check("sb_addr", c_addr, 32'h203);

    // byte load, negative lane 2
    ack_after = 0; rdata_val = 32'h00800000;
    push(32'h100C, 32'h2, 5'd6, MTR_MEM, 1'b1, 1'b0, 1'b1,
         32'hFFFFFF80);
    run_op(32'h100C, 32'h2, 32'h0, 5'd6, MTR_MEM,
           1'b1, 1'b0, 1'b1, 1'b0);
    check("lb_stall", 32'(n_stall), 32'd1);
    check("lb_be", 32'(c_be), 32'h4);

    // byte load lane 1, stray ack while idle must be ignored
    force_ack = 1'b1;
    ack_after = 2; rdata_val = 32'h12345678;
    push(32'h1010, 32'h11, 5'd7, MTR_MEM, 1'b1, 1'b0, 1'b1,
         32'h00000056);
    run_op(32'h1010, 32'h11, 32'h0, 5'd7, MTR_MEM,
           1'b1, 1'b0, 1'b1, 1'b0);
    force_ack = 1'b0;
    check("lb1_stall", 32'(n_stall), 32'd3);
    check("lb1_be", 32'(c_be), 32'h2);

    // MemRead and MemWrite together act as a store
    ack_after = 0;
    push(32'h1014, 32'h300, 5'd0, MTR_ALU, 1'b0, 1'b0, 1'b0, '0);
    run_op(32'h1014, 32'h300, 32'h11223344, 5'd0, MTR_ALU,
           1'b0, 1'b1, 1'b1, 1'b1);
    check("rw_we", 32'(c_we), 32'd1);
    check("rw_wdata", c_wdata, 32'h11223344);
    check("rw_be", 32'(c_be), 32'hF);

    // misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    push(32'h1018, 32'h102, 5'd7, MTR_MEM, 1'b0, 1'b1, 1'b0, '0);
    run_op(32'h1018, 32'h102, 32'h0, 5'd7, MTR_MEM,
           1'b1, 1'b1, 1'b1, 1'b0);
    check("mis_req", 32'(n_req), 32'd0);
    check("mis_stall", 32'(n_stall), 32'd0);
`else
    ack_after = 0; rdata_val = 32'hCAFEF00D;
    push(32'h1018, 32'h102, 5'd7, MTR_MEM, 1'b1, 1'b0, 1'b1,
         32'hCAFEF00D);
    run_op(32'h1018, 32'h102, 32'h0, 5'd7, MTR_MEM,
           1'b1, 1'b1, 1'b1, 1'b0);
    check("mis_addr", c_addr, 32'h100);
    check("mis_be", 32'(c_be), 32'hF);
`endif

    // no ack: abort after MAX_WAIT BUSY cycles
    ack_after = -1;
    push(32'h101C, 32'h400, 5'd8, MTR_MEM, 1'b0, 1'b1, 1'b0, '0);
    run_op(32'h101C, 32'h400, 32'h0, 5'd8, MTR_MEM,
           1'b1, 1'b1, 1'b1, 1'b0);
    check("to_req", 32'(n_req), MAX_WAIT);
    check("to_stall", 32'(n_stall), MAX_WAIT);

    push(32'h1020, 32'h77, 5'd9, MTR_PC4, 1'b1, 1'b0, 1'b0, '0);
    run_op(32'h1020, 32'h77, 32'h0, 5'd9, MTR_PC4,
           1'b1, 1'b1, 1'b0, 1'b0);
    check("to_vprev", 32'(v_first), 32'd1);

    // reset in the middle of a BUSY access
    @(posedge clk);
    #1;
    pc = 32'h1024; ALUresult = 32'h500; rd = 5'd10;
    MemtoReg = MTR_MEM; RegWrite = 1'b1; WordOrByte = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_req", 32'(bus.dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rstb_req", 32'(bus.dmem_req), 32'd0);
    check("rstb_valid", 32'(valid_out), 32'd0);
    check("rstb_err", 32'(err_out), 32'd0);

    push(32'h1028, 32'h99, 5'd11, MTR_ALU, 1'b1, 1'b0, 1'b0, '0);
    run_op(32'h1028, 32'h99, 32'h0, 5'd11, MTR_ALU,
           1'b1, 1'b1, 1'b0, 1'b0);
    check("rstb_vprev", 32'(v_first), 32'd0);
    check("rstb_stall", 32'(n_stall), 32'd0);

    push(32'h102C, 32'h0, 5'd12, MTR_ALU, 1'b0, 1'b0, 1'b0, '0);
    run_op(32'h102C, 32'h0, 32'h0, 5'd12, MTR_ALU,
           1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_lat", 32'(v_first), 32'd1);

    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
